// File: rtl/dither_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : dither_pixel_packer
// Description : Packs 4-pixel dithered groups MSB-first into 32-bit words,
//               flushes at end of line, 2-entry registered output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dither_pixel_packer #(
  parameter int OUTPUT_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OUTPUT_BITS*4-1:0]   din,
  input  logic                       din_valid,
  input  logic                       din_eol,
  output logic                       din_ready,
  output logic [31:0]                dout,
  output logic                       dout_last,
  output logic                       dout_valid,
  input  logic                       dout_ready
);

  localparam int GROUP_W = OUTPUT_BITS * 4;
  localparam int GROUPS  = 32 / GROUP_W;
  localparam int CNT_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(GROUPS - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [5:0]       c_group_w  = 6'(GROUP_W);
  localparam logic [1:0]       c_fifo_full = 2'd2;

  logic [31:0]      r_sr;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]      r_e0_data;
  logic             r_e0_last;
  logic [31:0]      r_e1_data;
  logic             r_e1_last;
  logic [1:0]       r_count;

  logic             w_accept;
  logic             w_complete;
  logic             w_pop;
  logic [31:0]      w_din_msb;
  logic [5:0]       w_offset;
  logic [31:0]      w_word;

  assign din_ready  = (r_count != c_fifo_full);
  assign w_accept   = din_valid && din_ready;
  assign w_pop      = dout_valid && dout_ready;
  assign w_complete = w_accept && ((r_cnt == c_last_cnt) || din_eol);

  // Group lands at bit offset cnt*GROUP_W below the MSB; lower bits of sr are still zero.
  assign w_din_msb = {din, {(32 - GROUP_W){1'b0}}};
  assign w_offset  = 6'(r_cnt) * c_group_w;
  assign w_word    = r_sr | (w_din_msb >> w_offset);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else begin
        r_sr  <= w_word;
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  // Entry 0 is always the head; entry 1 shifts down on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0_data <= '0;
      r_e0_last <= 1'b0;
      r_e1_data <= '0;
      r_e1_last <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      case ({w_complete, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_e0_data <= w_word;
            r_e0_last <= din_eol;
          end else begin
            r_e1_data <= w_word;
            r_e1_last <= din_eol;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_e0_data <= r_e1_data;
          r_e0_last <= r_e1_last;
          r_count   <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == c_fifo_full) begin
            r_e0_data <= r_e1_data;
            r_e0_last <= r_e1_last;
            r_e1_data <= w_word;
            r_e1_last <= din_eol;
          end else begin
            r_e0_data <= w_word;
            r_e0_last <= din_eol;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign dout       = r_e0_data;
  assign dout_last  = r_e0_last;
  assign dout_valid = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_dither_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dither_pixel_packer
// Description : Directed self-checking bench for 1bpp and 4bpp packers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dither_pixel_packer;

  logic        clk;
  logic        rst;

  logic [3:0]  din1;
  logic        v1, e1, rdy1, last1, dv1, dr1;
  logic [31:0] dout1;

  logic [15:0] din4;
  logic        v4, e4, rdy4, last4, dv4, dr4;
  logic [31:0] dout4;

  int errors = 0;
  int checks = 0;

  dither_pixel_packer #(.OUTPUT_BITS(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .din        (din1),
    .din_valid  (v1),
    .din_eol    (e1),
    .din_ready  (rdy1),
    .dout       (dout1),
    .dout_last  (last1),
    .dout_valid (dv1),
    .dout_ready (dr1)
  );

  dither_pixel_packer #(.OUTPUT_BITS(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .din        (din4),
    .din_valid  (v4),
    .din_eol    (e4),
    .din_ready  (rdy4),
    .dout       (dout4),
    .dout_last  (last4),
    .dout_valid (dv4),
    .dout_ready (dr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] line2 [8];
    line2 = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};

    rst = 1'b1;
    din1 = '0; v1 = 1'b0; e1 = 1'b0; dr1 = 1'b1;
    din4 = '0; v4 = 1'b0; e4 = 1'b0; dr4 = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_dv1",   32'(dv1),   32'd0);
    chk("rst_dout1", dout1,      32'd0);
    chk("rst_last1", 32'(last1), 32'd0);
    chk("rst_rdy1",  32'(rdy1),  32'd1);
    chk("rst_dv4",   32'(dv4),   32'd0);
    chk("rst_rdy4",  32'(rdy4),  32'd1);

    // Full 1bpp line, eol on the filling group
    for (int g = 1; g <= 8; g++) begin
      din1 = 4'(g); v1 = 1'b1; e1 = (g == 8);
      chk("t1_rdy", 32'(rdy1), 32'd1);
      chk("t1_dv_before", 32'(dv1), 32'd0);
      tick();
    end
    v1 = 1'b0; e1 = 1'b0;
    chk("t1_dv",   32'(dv1),   32'd1);
    chk("t1_dout", dout1,      32'h12345678);
    chk("t1_last", 32'(last1), 32'd1);
    chk("t1_rdy_after", 32'(rdy1), 32'd1);
    tick();
    chk("t1_no_extra_word", 32'(dv1), 32'd0);

    // 4bpp: full word then eol partial
    din4 = 16'hDEAD; v4 = 1'b1; e4 = 1'b0;
    tick();
    din4 = 16'hBEEF;
    tick();
    chk("t2_dout_a", dout4,      32'hDEADBEEF);
    chk("t2_last_a", 32'(last4), 32'd0);
    chk("t2_dv_a",   32'(dv4),   32'd1);
    din4 = 16'h0001; e4 = 1'b1;
    tick();
    v4 = 1'b0; e4 = 1'b0;
    chk("t2_dout_b", dout4,      32'h00010000);
    chk("t2_last_b", 32'(last4), 32'd1);
    chk("t2_dv_b",   32'(dv4),   32'd1);
    tick();
    chk("t2_empty", 32'(dv4), 32'd0);

    // 1bpp partial flush, then next line restarts at MSB
    for (int g = 1; g <= 3; g++) begin
      din1 = 4'(g); v1 = 1'b1; e1 = (g == 3);
      tick();
    end
    e1 = 1'b0;
    chk("t3_dout_partial", dout1,      32'h12300000);
    chk("t3_last_partial", 32'(last1), 32'd1);
    for (int g = 0; g < 8; g++) begin
      din1 = line2[g]; v1 = 1'b1;
      tick();
    end
    v1 = 1'b0;
    chk("t3_dout_line2", dout1,      32'hABCDEF01);
    chk("t3_last_line2", 32'(last1), 32'd0);
    chk("t3_dv_line2",   32'(dv1),   32'd1);
    tick();
    chk("t3_empty", 32'(dv1), 32'd0);

    // Backpressure: fill both FIFO entries
    dr1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din1 = 4'(i); v1 = 1'b1;
      chk("t4_rdy_fill", 32'(rdy1), 32'd1);
      tick();
    end
    chk("t4_rdy_full", 32'(rdy1), 32'd0);
    chk("t4_dout_w1",  dout1,     32'h01234567);
    din1 = 4'hF;
    tick();
    chk("t4_hold_dout", dout1,     32'h01234567);
    chk("t4_hold_rdy",  32'(rdy1), 32'd0);
    tick();
    chk("t4_hold_dout2", dout1,    32'h01234567);
    dr1 = 1'b1;
    tick();
    dr1 = 1'b0;
    chk("t4_pop_dout", dout1,     32'h89ABCDEF);
    chk("t4_pop_rdy",  32'(rdy1), 32'd1);
    tick();
    for (int g = 1; g <= 7; g++) begin
      din1 = 4'(g);
      tick();
    end
    v1 = 1'b0;
    chk("t4_rdy_full2", 32'(rdy1), 32'd0);
    dr1 = 1'b1;
    chk("t4_drain_w2", dout1, 32'h89ABCDEF);
    tick();
    chk("t4_drain_w3", dout1, 32'hF1234567);
    chk("t4_drain_dv", 32'(dv1), 32'd1);
    tick();
    chk("t4_drained", 32'(dv1), 32'd0);

    // Reset mid-word discards the partial accumulator
    for (int g = 1; g <= 3; g++) begin
      din1 = 4'(g); v1 = 1'b1;
      tick();
    end
    v1 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_dv",   32'(dv1),  32'd0);
    chk("t5_dout", dout1,     32'd0);
    chk("t5_rdy",  32'(rdy1), 32'd1);
    for (int g = 8; g >= 1; g--) begin
      din1 = 4'(g); v1 = 1'b1; e1 = (g == 1);
      tick();
    end
    v1 = 1'b0; e1 = 1'b0;
    chk("t5_dout_clean", dout1,      32'h87654321);
    chk("t5_last_clean", 32'(last1), 32'd1);
    tick();
    chk("t5_empty", 32'(dv1), 32'd0);

    // Reset with a full FIFO and stalled consumer
    dr1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din1 = 4'(15 - i); v1 = 1'b1;
      tick();
    end
    v1 = 1'b0;
    chk("t6_full", 32'(rdy1), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_dv",   32'(dv1),  32'd0);
    chk("t6_rdy",  32'(rdy1), 32'd1);
    chk("t6_dout", dout1,     32'd0);
    dr1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_stale", 32'(dv1), 32'd0);
    end
    din1 = 4'h5; v1 = 1'b1; e1 = 1'b1;
    tick();
    v1 = 1'b0; e1 = 1'b0;
    chk("t6_fresh_dout", dout1,      32'h50000000);
    chk("t6_fresh_last", 32'(last1), 32'd1);
    tick();
    chk("t6_fresh_empty", 32'(dv1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dither_pixel_packer.md
Name: dither_pixel_packer

Overview:
Downstream consumer of the blue-noise dithering stage. Collects the 4-pixel dithered groups (4 or 16 bits per group) into 32-bit words, MSB-first, for the framebuffer/DMA write path. Flushes partial words at end of line and buffers completed words in a 2-entry output FIFO with valid/ready handshake. Upstream must align din_valid/din_eol with the dither stage's 1-cycle output latency.

Parameters:
OUTPUT_BITS, 1, bits per pixel of dithered input; legal values 1 or 4 (matches dither stage).
GROUP_W, OUTPUT_BITS*4, derived (localparam): bits per input group.
GROUPS, 32/GROUP_W, derived (localparam): groups per output word (8 for 1bpp, 2 for 4bpp).

Ports:
clk  input  1  clock; single clock domain.
rst  input  1  synchronous, active-high reset.
din  input  GROUP_W  dithered group; pixel 0 in the MSBs.
din_valid  input  1  din holds a valid group.
din_eol  input  1  qualifies din_valid: this group is the last of the line.
din_ready  output  1  packer can accept a group this cycle.
dout  output  32  packed word; first group in bits [31 -: GROUP_W].
dout_last  output  1  word is the last word of a line.
dout_valid  output  1  dout/dout_last valid.
dout_ready  input  1  consumer accepts the word.

Behaviour:
- Accept: din_valid && din_ready. Pop: dout_valid && dout_ready.
- din_ready = !fifo_full (combinational from FIFO occupancy only; independent of din_valid and dout_ready). When full, no group is accepted, including non-completing groups.
- Accumulator: sr[31:0] and cnt (0..GROUPS-1). On accept, din is written to sr[31 - cnt*GROUP_W -: GROUP_W].
- Word completion on accept when cnt == GROUPS-1 or din_eol:
  - push {sr with din merged, unfilled bits = 0, last = din_eol} into the FIFO;
  - cnt <= 0, sr <= 0.
- Otherwise, on accept: cnt <= cnt+1.
- din_eol on the group that also fills the word produces one word with last=1. It does not produce an extra empty word.
- FIFO: 2 entries, registered.
  - dout, dout_last and dout_valid are driven from the head entry.
  - A word pushed in cycle N is visible on dout in cycle N+1.
  - Push and pop in the same cycle are legal at occupancy 1 (occupancy stays 1).
  - At occupancy 2, a push and pop cannot coincide, because din_ready = 0.
- Throughput: with dout_ready held high, one group is accepted every cycle without stall.
- dout holds stable while dout_valid && !dout_ready.
- Reset (at any time, including mid-line or mid-handshake):
  - cnt=0, sr=0, FIFO empty.
  - dout_valid=0, dout=0, dout_last=0, din_ready=1 in the cycle after rst is sampled.
  - Partial words and buffered words are discarded.
- din ignored when din_valid=0. din_eol ignored unless accepted.
- No overflow is possible. An upstream that ignores din_ready loses groups silently. This is upstream's responsibility; the dither stage has no enable, so upstream must hold its input stable while stalled.

Test Plan:
- 1bpp, dout_ready=1: groups 1,2,3,4,5,6,7,8 on consecutive cycles, din_eol on group 8 -> one word 32'h12345678, last=1, one cycle after group 8; din_ready stays 1.
- 4bpp: 16'hDEAD then 16'hBEEF, no eol, then 16'h0001 with eol -> words 32'hDEADBEEF (last=0), then 32'h00010000 (last=1).
- 1bpp partial flush: groups 1,2,3 with eol on 3 -> 32'h12300000, last=1; next line groups A..H -> 32'hABCDEFxx style packing restarts at MSB (e.g. A,B,C,D,E,F,0,1 -> 32'hABCDEF01).
- Backpressure: dout_ready=0, stream 1bpp groups continuously -> din_ready drops to 0 the cycle after the 2nd word is pushed (16 groups accepted). dout holds 32'h... stable. Raising dout_ready for one cycle -> one pop, din_ready=1 the next cycle, no group lost or duplicated.
- Reset mid-word: accept groups 1,2,3, then assert rst one cycle -> dout_valid=0, dout=0. Then groups 8..1 -> 32'h87654321 with no residue of 1,2,3.
- Reset with full FIFO and dout_ready=0 -> dout_valid=0, din_ready=1 the next cycle; no stale word ever emitted afterwards.
